// File: rtl/ascon_fault_check_ctrl.sv
// Run sequencer around the FC wrapper: encrypt, decrypt the result, cross-check
// plaintext and tag, and release cipher_text/tag only when both match.
module ascon_fault_check_ctrl #(
  parameter int y              = 40,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [y-1:0]   plain_text,
  output logic           enc_start,
  input  logic           enc_ready,
  input  logic [y-1:0]   cipher_text,
  input  logic [127:0]   tag,
  output logic           dec_start,
  input  logic           dec_ready,
  input  logic [y-1:0]   dec_plain_text,
  input  logic [127:0]   dec_tag,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2:0]     fault_code,
  output logic [y-1:0]   ct_out,
  output logic [127:0]   tag_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENC_GO, S_ENC_WAIT, S_DEC_GO, S_DEC_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [y-1:0]   pt_q, pt_d;
  logic [y-1:0]   ct_q, ct_d;
  logic [127:0]   tag_q, tag_d;
  logic [y-1:0]   dec_pt_q, dec_pt_d;
  logic [127:0]   dec_tag_q, dec_tag_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           enc_rdy_prev_q, enc_rdy_prev_d;
  logic           dec_rdy_prev_q, dec_rdy_prev_d;
  logic           enc_start_q, enc_start_d;
  logic           dec_start_q, dec_start_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [2:0]     fault_q, fault_d;
  logic [y-1:0]   ct_out_q, ct_out_d;
  logic [127:0]   tag_out_q, tag_out_d;

  logic enc_done, dec_done, limit_hit, pt_mis, tag_mis;

  // Only a fresh 0->1 transition counts, so a ready left high by a previous run is ignored.
  assign enc_done  = enc_ready & ~enc_rdy_prev_q;
  assign dec_done  = dec_ready & ~dec_rdy_prev_q;
  assign limit_hit = (cnt_q == CNT_LIMIT);
  assign pt_mis    = (dec_pt_q != pt_q);
  assign tag_mis   = (dec_tag_q != tag_q);

  always_comb begin
    state_d        = state_q;
    pt_d           = pt_q;
    ct_d           = ct_q;
    tag_d          = tag_q;
    dec_pt_d       = dec_pt_q;
    dec_tag_d      = dec_tag_q;
    cnt_d          = cnt_q;
    enc_rdy_prev_d = enc_ready;
    dec_rdy_prev_d = dec_ready;
    enc_start_d    = 1'b0;
    dec_start_d    = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    pass_d         = pass_q;
    fault_d        = fault_q;
    ct_out_d       = ct_out_q;
    tag_out_d      = tag_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pt_d        = plain_text;
          pass_d      = 1'b0;
          fault_d     = '0;
          ct_out_d    = '0;
          tag_out_d   = '0;
          busy_d      = 1'b1;
          enc_start_d = 1'b1;
          state_d     = S_ENC_GO;
        end
      end
      S_ENC_GO: begin
        cnt_d   = '0;
        state_d = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        if (enc_done) begin
          ct_d        = cipher_text;
          tag_d       = tag;
          dec_start_d = 1'b1;
          state_d     = S_DEC_GO;
        end else if (limit_hit) begin
          fault_d = 3'b100;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DEC_GO: begin
        cnt_d   = '0;
        state_d = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        if (dec_done) begin
          dec_pt_d  = dec_plain_text;
          dec_tag_d = dec_tag;
          state_d   = S_CHECK;
        end else if (limit_hit) begin
          fault_d = 3'b100;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        fault_d   = {1'b0, tag_mis, pt_mis};
        pass_d    = ~(pt_mis | tag_mis);
        ct_out_d  = (pt_mis | tag_mis) ? '0 : ct_q;
        tag_out_d = (pt_mis | tag_mis) ? '0 : tag_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pt_q           <= '0;
      ct_q           <= '0;
      tag_q          <= '0;
      dec_pt_q       <= '0;
      dec_tag_q      <= '0;
      cnt_q          <= '0;
      enc_rdy_prev_q <= 1'b0;
      dec_rdy_prev_q <= 1'b0;
      enc_start_q    <= 1'b0;
      dec_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fault_q        <= '0;
      ct_out_q       <= '0;
      tag_out_q      <= '0;
    end else begin
      state_q        <= state_d;
      pt_q           <= pt_d;
      ct_q           <= ct_d;
      tag_q          <= tag_d;
      dec_pt_q       <= dec_pt_d;
      dec_tag_q      <= dec_tag_d;
      cnt_q          <= cnt_d;
      enc_rdy_prev_q <= enc_rdy_prev_d;
      dec_rdy_prev_q <= dec_rdy_prev_d;
      enc_start_q    <= enc_start_d;
      dec_start_q    <= dec_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fault_q        <= fault_d;
      ct_out_q       <= ct_out_d;
      tag_out_q      <= tag_out_d;
    end
  end

  assign enc_start  = enc_start_q;
  assign dec_start  = dec_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fault_code = fault_q;
  assign ct_out     = ct_out_q;
  assign tag_out    = tag_out_q;

endmodule

// File: tb/tb_ascon_fault_check_ctrl.sv
// Bench for ascon_fault_check_ctrl: a behavioural FC (XOR-keyed cipher) answers the
// start pulses, and each scenario task compares the released result with the model's.
module tb_ascon_fault_check_ctrl;

  localparam int Y  = 40;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [Y-1:0]   plain_text;
  logic           enc_start;
  logic           enc_ready;
  logic [Y-1:0]   cipher_text;
  logic [127:0]   tag;
  logic           dec_start;
  logic           dec_ready;
  logic [Y-1:0]   dec_plain_text;
  logic [127:0]   dec_tag;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2:0]     fault_code;
  logic [Y-1:0]   ct_out;
  logic [127:0]   tag_out;

  ascon_fault_check_ctrl #(.y(Y), .TIMEOUT_CYCLES(TO), .TW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .plain_text(plain_text),
    .enc_start(enc_start), .enc_ready(enc_ready), .cipher_text(cipher_text), .tag(tag),
    .dec_start(dec_start), .dec_ready(dec_ready), .dec_plain_text(dec_plain_text),
    .dec_tag(dec_tag), .busy(busy), .done(done), .pass(pass), .fault_code(fault_code),
    .ct_out(ct_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FC model configuration, written only by the scenario tasks
  logic [Y-1:0]  key_r = '0;
  logic [127:0]  tag_r = '0;
  int            enc_lat = 2;
  int            dec_lat = 2;
  bit            enc_hang = 1'b0;
  bit            stale_pre = 1'b0;
  bit            stale_resp = 1'b0;
  bit            flip_pt = 1'b0;
  bit            flip_tag = 1'b0;
  logic [Y-1:0]  fc_pt;

  // Encryption side of the FC model: cipher = pt ^ key, tag = chosen tag
  initial begin
    enc_ready   = 1'b0;
    cipher_text = '0;
    tag         = '0;
    forever begin
      @(negedge clk);
      if (enc_hang) begin
        enc_ready = 1'b0;
      end else if (enc_start === 1'b1) begin
        fc_pt = plain_text;
        if (stale_resp) begin
          repeat (2) @(negedge clk);
          enc_ready = 1'b0;
          repeat (5) @(negedge clk);
        end else begin
          enc_ready = 1'b0;
          repeat (enc_lat) @(negedge clk);
        end
        cipher_text = fc_pt ^ key_r;
        tag         = tag_r;
        enc_ready   = 1'b1;
      end else if (stale_pre) begin
        cipher_text = ~(plain_text ^ key_r);
        tag         = ~tag_r;
        enc_ready   = 1'b1;
      end
    end
  end

  // Decryption side: inverts the cipher on the FC's own cipher_text, optional bit-0 faults
  initial begin
    dec_ready      = 1'b0;
    dec_plain_text = '0;
    dec_tag        = '0;
    forever begin
      @(negedge clk);
      if (dec_start === 1'b1) begin
        dec_ready = 1'b0;
        repeat (dec_lat) @(negedge clk);
        dec_plain_text = (cipher_text ^ key_r) ^ {{(Y-1){1'b0}}, flip_pt};
        dec_tag        = tag ^ {127'b0, flip_tag};
        dec_ready      = 1'b1;
      end
    end
  end

  function automatic logic [Y-1:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[Y-1:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Results of the last run
  int            n_enc, n_dec, n_done, c_enc, c_done;
  bit            got_done;
  logic [172:0]  res;       // {busy, pass, fault_code, ct_out, tag_out} at the done cycle
  logic          pass_after;

  task automatic do_run(input logic [Y-1:0] p, input bit extra);
    n_enc = 0; n_dec = 0; n_done = 0; c_enc = -1; c_done = -1; got_done = 1'b0;
    res = '0; pass_after = 1'b0;
    @(negedge clk);
    plain_text = p;
    start      = 1'b1;
    for (int i = 0; i < 300 && !got_done; i++) begin
      @(negedge clk);
      if (enc_start === 1'b1) begin n_enc++; if (c_enc < 0) c_enc = i; end
      if (dec_start === 1'b1) n_dec++;
      if (done === 1'b1) begin
        n_done++; got_done = 1'b1; c_done = i;
        res = {busy, pass, fault_code, ct_out, tag_out};
      end
      start = extra && (i % 3 == 1) && !got_done;
      if (i == 1) plain_text = rnd40();
    end
    start = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL run_done_timeout: no done within 300 cycles, required a done pulse");
    end
    repeat (3) begin
      @(negedge clk);
      if (enc_start === 1'b1) n_enc++;
      if (dec_start === 1'b1) n_dec++;
      if (done === 1'b1) n_done++;
    end
    pass_after = pass;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; plain_text = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, fault_code, ct_out, tag_out, enc_start, dec_start} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fault=%b ct=%h tag=%h es=%b ds=%b, required all 0",
               busy, done, pass, fault_code, ct_out, tag_out, enc_start, dec_start);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    logic [Y-1:0] pt;
    pt = 40'h0123456789;
    key_r = pt ^ 40'hA5A5A5A5A5; tag_r = 128'h1234;
    flip_pt = 1'b0; flip_tag = 1'b0; enc_lat = 3; dec_lat = 2;
    do_run(pt, 1'b0);
    checks++;
    if (res !== {1'b0, 1'b1, 3'b000, 40'hA5A5A5A5A5, 128'h1234}) begin
      errors++;
      $display("FAIL clean_result: got %h, required %h", res, {1'b0, 1'b1, 3'b000, 40'hA5A5A5A5A5, 128'h1234});
    end
    checks++;
    if (n_done != 1 || n_enc != 1 || n_dec != 1) begin
      errors++;
      $display("FAIL clean_pulses: got done=%0d enc=%0d dec=%0d, required 1 1 1", n_done, n_enc, n_dec);
    end
    checks++;
    if (pass_after !== 1'b1) begin
      errors++;
      $display("FAIL clean_pass_held: got %b, required 1", pass_after);
    end
  endtask

  task automatic test_mismatch();
    logic [172:0] exp;
    for (int k = 1; k < 4; k++) begin
      logic [Y-1:0] pt;
      pt = rnd40(); key_r = rnd40(); tag_r = rnd128();
      flip_pt = k[0]; flip_tag = k[1]; enc_lat = 1 + k; dec_lat = 4 - k;
      do_run(pt, 1'b0);
      exp = {1'b0, 1'b0, 1'b0, flip_tag, flip_pt, 40'b0, 128'b0};
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL mismatch_%0d: got %h, required %h", k, res, exp);
      end
    end
    flip_pt = 1'b0; flip_tag = 1'b0;
  endtask

  task automatic test_timeout();
    enc_hang = 1'b1;
    repeat (2) @(negedge clk);
    do_run(rnd40(), 1'b0);
    enc_hang = 1'b0;
    checks++;
    if (c_done - c_enc != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got done %0d cycles after enc_start, required %0d", c_done - c_enc, TO + 1);
    end
    checks++;
    if (res !== {1'b0, 1'b0, 3'b100, 40'b0, 128'b0}) begin
      errors++;
      $display("FAIL timeout_result: got %h, required fault_code=100 and all else 0", res);
    end
    checks++;
    if (n_dec != 0 || n_enc != 1) begin
      errors++;
      $display("FAIL timeout_pulses: got dec=%0d enc=%0d, required 0 1", n_dec, n_enc);
    end
  endtask

  task automatic test_stale();
    logic [Y-1:0] pt;
    pt = rnd40(); key_r = rnd40(); tag_r = rnd128();
    plain_text = pt;
    stale_pre = 1'b1; stale_resp = 1'b1;
    repeat (3) @(negedge clk);
    stale_pre = 1'b0;
    do_run(pt, 1'b0);
    stale_resp = 1'b0;
    checks++;
    if (res !== {1'b0, 1'b1, 3'b000, pt ^ key_r, tag_r}) begin
      errors++;
      $display("FAIL stale_ready: got %h, required %h", res, {1'b0, 1'b1, 3'b000, pt ^ key_r, tag_r});
    end
  endtask

  task automatic test_back_to_back();
    logic [Y-1:0] pt;
    for (int k = 0; k < 2; k++) begin
      pt = rnd40(); key_r = rnd40(); tag_r = rnd128(); enc_lat = 4; dec_lat = 5;
      do_run(pt, k == 0);
      checks++;
      if (n_enc != 1 || n_done != 1 || res !== {1'b0, 1'b1, 3'b000, pt ^ key_r, tag_r}) begin
        errors++;
        $display("FAIL back_to_back_%0d: got enc=%0d done=%0d res=%h, required 1 1 %h",
                 k, n_enc, n_done, res, {1'b0, 1'b1, 3'b000, pt ^ key_r, tag_r});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    key_r = rnd40(); tag_r = rnd128(); enc_lat = 2; dec_lat = 20;
    @(negedge clk);
    plain_text = rnd40(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dec_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_dec_start: got no dec_start in 50 cycles, required one");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, fault_code, ct_out, tag_out, enc_start, dec_start} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b pass=%b fault=%b ct=%h tag=%h es=%b ds=%b, required all 0",
               busy, done, pass, fault_code, ct_out, tag_out, enc_start, dec_start);
    end
    rst = 1'b0;
    repeat (25) @(negedge clk);
    dec_lat = 3;
    do_run(rnd40(), 1'b0);
    checks++;
    if (res[171] !== 1'b1 || res[170:168] !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_rerun: got pass=%b fault=%b, required 1 000", res[171], res[170:168]);
    end
  endtask

  task automatic test_random();
    logic [172:0] exp;
    logic [Y-1:0] pt;
    bit ok;
    for (int k = 0; k < 8; k++) begin
      pt = rnd40(); key_r = rnd40(); tag_r = rnd128();
      enc_lat = $urandom_range(1, 6); dec_lat = $urandom_range(1, 6);
      flip_pt = $urandom_range(0, 3) == 0; flip_tag = $urandom_range(0, 3) == 0;
      do_run(pt, $urandom_range(0, 1) == 1);
      ok = !flip_pt && !flip_tag;
      exp = {1'b0, ok, 1'b0, flip_tag, flip_pt, ok ? pt ^ key_r : 40'b0, ok ? tag_r : 128'b0};
      checks++;
      if (res !== exp || n_done != 1 || n_enc != 1) begin
        errors++;
        $display("FAIL random_%0d: got %h done=%0d enc=%0d, required %h 1 1", k, res, n_done, n_enc, exp);
      end
    end
    flip_pt = 1'b0; flip_tag = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; plain_text = '0;
    test_reset();
    test_clean();
    test_mismatch();
    test_timeout();
    test_stale();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
